req_encoder_4x2: RTL

//   Sequential 4-to-2 encoder: the inverse end of the 2x4 decoder path.
//   - Captures a multi-hot request vector through a valid/ready handshake.
//   - Emits the binary index of every set bit, lowest index first, one per output handshake.
//   - Sits upstream of decoder_2x4; feeding each y into the decoder regenerates the one-hot lines.

---
 rtl/enc_pkg.sv | 12 +
 rtl/req_encoder_4x2_lsb_enc.sv | 23 ++
 rtl/req_encoder_4x2.sv | 76 +++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the request encoder: line count, index width and FSM states.
package enc_pkg;

   localparam int ENC_N = 4;
   localparam int ENC_W = $clog2(ENC_N);

   typedef enum logic {
      IDLE,
      SERVE
   } enc_state_t;

endpackage

// File: rtl/req_encoder_4x2_lsb_enc.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit of vec, plus an any-set flag.
module lsb_enc_4x2
   import enc_pkg::*;
(
   input  logic [ENC_N-1:0] vec,
   output logic [ENC_W-1:0] idx,
   output logic             any
);

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      idx = '0;
      any = 1'b0;
      // Scan from the top down so the lowest set bit is the last one written.
      for (int i = ENC_N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = ENC_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/req_encoder_4x2.sv
// Sequential 4-to-2 encoder: accepts a multi-hot request vector and emits the index of
// each set bit, lowest first, one per output handshake.
module req_encoder_4x2
   import enc_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ENC_N-1:0] req,
   input  logic             req_valid,
   output logic             req_ready,
   output logic [ENC_W-1:0] y,
   output logic             y_valid,
   input  logic             y_ready,
   output logic [ENC_N-1:0] pend,
   output logic             err_zero
);

   enc_state_t       state_q, state_d;
   logic [ENC_N-1:0] pend_q, pend_d;
   logic [ENC_W-1:0] y_q, y_d;
   logic             err_q, err_d;
   logic             pend_any;

   // y is registered from the encoding of the next pending mask, so it lines up with pend.
   lsb_enc_4x2 u_lsb_enc (
      .vec (pend_d),
      .idx (y_d),
      .any (pend_any)
   );

   always_comb begin
      pend_d = pend_q;
      err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req != '0) pend_d = req;
               else           err_d  = 1'b1;
            end
         end
         SERVE: begin
            if (y_ready) pend_d = pend_q & ~(ENC_N'(1) << y_q);
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (req_valid && req != '0) state_d = SERVE;
         SERVE: if (!pend_any)              state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         y_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignment so all of them update from the same pre-edge values.
         state_q <= state_d;
         pend_q  <= pend_d;
         y_q     <= y_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign y_valid   = (state_q == SERVE);
   assign y         = y_q;
   assign pend      = pend_q;
   assign err_zero  = err_q;

endmodule
